// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the 8-bit CPU controller: opcodes, ALU ops, write-data select,
// FSM states and instruction field positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_MOV  = 4'h6,
        OP_LDI  = 4'h7,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        WSEL_ALU = 2'd0,
        WSEL_IMM = 2'd1,
        WSEL_B   = 2'd2
    } wsel_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_FETCH_IMM = 3'd3,
        S_EXEC      = 3'd4,
        S_HALT      = 3'd5,
        S_STEP_WAIT = 3'd6
    } state_e;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;
    localparam int RA_HI  = 3;
    localparam int RA_LO  = 2;
    localparam int RB_HI  = 1;
    localparam int RB_LO  = 0;

    function automatic opcode_e get_opcode(input logic [7:0] ir);
        return opcode_e'(ir[OPC_HI:OPC_LO]);
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Instruction-memory req/ack port between the CPU controller (master) and
// the instruction memory (slave).
interface cpu_ctrl_if #(
    parameter int unsigned PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_rdata;
    logic            imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction decode: IR -> immediate need, ALU/halt class,
// ALU opcode, write-data source and register write intent.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [7:0] i_ir,
    output logic       o_needs_imm,
    output logic       o_is_alu,
    output logic       o_is_halt,
    output alu_op_e    o_alu_op,
    output wsel_e      o_wsel,
    output logic       o_we
);

    opcode_e w_opc;

    assign w_opc = get_opcode(i_ir);

    // Opcode classification; A..E fall into the default and behave as NOP
    always_comb begin
        o_needs_imm = 1'b0;
        o_is_alu    = 1'b0;
        o_is_halt   = 1'b0;
        o_alu_op    = ALU_ADD;
        o_wsel      = WSEL_ALU;
        o_we        = 1'b0;
        case (w_opc)
            OP_ADD: begin o_is_alu = 1'b1; o_we = 1'b1; o_alu_op = ALU_ADD; end
            OP_SUB: begin o_is_alu = 1'b1; o_we = 1'b1; o_alu_op = ALU_SUB; end
            OP_AND: begin o_is_alu = 1'b1; o_we = 1'b1; o_alu_op = ALU_AND; end
            OP_OR:  begin o_is_alu = 1'b1; o_we = 1'b1; o_alu_op = ALU_OR;  end
            OP_XOR: begin o_is_alu = 1'b1; o_we = 1'b1; o_alu_op = ALU_XOR; end
            OP_MOV: begin o_we = 1'b1; o_wsel = WSEL_B; end
            OP_LDI: begin o_needs_imm = 1'b1; o_we = 1'b1; o_wsel = WSEL_IMM; end
            OP_JMP: begin o_needs_imm = 1'b1; end
            OP_JZ:  begin o_needs_imm = 1'b1; end
            OP_HALT: begin o_is_halt = 1'b1; end
            default: begin o_we = 1'b0; end
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit CPU.
// Optional single-step mode is enabled by defining CPU_CTRL_STEP_EN.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
`ifdef CPU_CTRL_STEP_EN
    input  logic            step,
`endif
    cpu_ctrl_if.master      imem,
    output logic            rf_we,
    output logic [1:0]      rf_selA,
    output logic [1:0]      rf_selB,
    output logic [1:0]      wsel,
    output logic [7:0]      imm,
    output logic [2:0]      alu_op,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    state_e          r_state;
    state_e          w_next;
    logic [7:0]      r_ir;
    logic [7:0]      r_imm;
    logic [PC_W-1:0] r_pc;
    logic            r_z;

    logic            w_needs_imm;
    logic            w_is_alu;
    logic            w_is_halt;
    logic            w_we;
    alu_op_e         w_alu_op;
    wsel_e           w_wsel;
    opcode_e         w_opc;

    logic            w_fetch_done;
    logic            w_imm_done;
    logic            w_take_jump;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;

    cpu_ctrl_decode u_decode (
        .i_ir        (r_ir),
        .o_needs_imm (w_needs_imm),
        .o_is_alu    (w_is_alu),
        .o_is_halt   (w_is_halt),
        .o_alu_op    (w_alu_op),
        .o_wsel      (w_wsel),
        .o_we        (w_we)
    );

    assign w_opc        = get_opcode(r_ir);
    // Acks only count in the two fetch states, so a stray ack is ignored
    assign w_fetch_done = (r_state == S_FETCH)     && imem.imem_ack;
    assign w_imm_done   = (r_state == S_FETCH_IMM) && imem.imem_ack;
    assign w_take_jump  = (r_state == S_EXEC) &&
                          ((w_opc == OP_JMP) || ((w_opc == OP_JZ) && r_z));
    assign w_pc_inc     = r_pc + PC_W'(1);
    assign w_target     = PC_W'(r_imm);

`ifdef CPU_CTRL_STEP_EN
    logic r_step_q;
    logic w_step_rise;

    assign w_step_rise = step && !r_step_q;

    // Previous step level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
                else     w_next = S_IDLE;
            end
            S_FETCH: begin
                if (imem.imem_ack) w_next = S_DECODE;
                else               w_next = S_FETCH;
            end
            S_DECODE: begin
                if (w_needs_imm)    w_next = S_FETCH_IMM;
                else if (w_is_halt) w_next = S_HALT;
                else                w_next = S_EXEC;
            end
            S_FETCH_IMM: begin
                if (imem.imem_ack) w_next = S_EXEC;
                else               w_next = S_FETCH_IMM;
            end
            S_EXEC: begin
`ifdef CPU_CTRL_STEP_EN
                if (run) w_next = S_STEP_WAIT;
                else     w_next = S_IDLE;
`else
                if (run) w_next = S_FETCH;
                else     w_next = S_IDLE;
`endif
            end
            S_HALT: begin
                if (run) w_next = S_HALT;
                else     w_next = S_IDLE;
            end
`ifdef CPU_CTRL_STEP_EN
            S_STEP_WAIT: begin
                if (!run)             w_next = S_IDLE;
                else if (w_step_rise) w_next = S_FETCH;
                else                  w_next = S_STEP_WAIT;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        imem.imem_req = 1'b0;
        rf_we         = 1'b0;
        halted        = 1'b0;
        case (r_state)
            S_FETCH:     imem.imem_req = 1'b1;
            S_FETCH_IMM: imem.imem_req = 1'b1;
            S_EXEC:      rf_we         = w_we;
            S_HALT:      halted        = 1'b1;
            default:     imem.imem_req = 1'b0;
        endcase
    end

    // Instruction, immediate and program counter; jumps override the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir  <= 8'h00;
            r_imm <= 8'h00;
            r_pc  <= PC_W'(RESET_PC);
        end else if (w_fetch_done) begin
            r_ir <= imem.imem_rdata;
            r_pc <= w_pc_inc;
        end else if (w_imm_done) begin
            r_imm <= imem.imem_rdata;
            r_pc  <= w_pc_inc;
        end else if (w_take_jump) begin
            r_pc <= w_target;
        end else begin
            r_pc <= r_pc;
        end
    end

    // Zero flag, updated only by ALU instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z <= 1'b0;
        end else if ((r_state == S_EXEC) && w_is_alu) begin
            r_z <= alu_zero;
        end else begin
            r_z <= r_z;
        end
    end

    assign imem.imem_addr = r_pc;
    assign pc             = r_pc;
    assign imm            = r_imm;
    assign rf_selA        = r_ir[RA_HI:RA_LO];
    assign rf_selB        = r_ir[RB_HI:RB_LO];
    assign alu_op         = w_alu_op;
    assign wsel           = w_wsel;

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Multi-cycle fetch/decode/execute controller for the custom 8-bit CPU.
- Fetches 8-bit instructions (plus an optional immediate byte) over a req/ack instruction-memory port.
- Drives the 4x8 register file (write enable, port A/B selects, write-data source) and the ALU opcode.
- Holds PC and the zero flag; sits between instruction memory, the register file and the ALU in the CPU top level.

Parameters:
PC_W, 8, program counter / instruction address width; PC wraps modulo 2^PC_W.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; high starts and keeps the CPU executing from IDLE
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address, equals PC
imem_rdata  in  8  fetched byte, valid when imem_ack=1
imem_ack  in  1  one-cycle fetch completion strobe
rf_we  out  1  register file write enable
rf_selA  out  2  read port A select, also the write destination
rf_selB  out  2  read port B select
wsel  out  2  write-data mux: 0=ALU result, 1=imm, 2=dataB
imm  out  8  latched immediate byte
alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
alu_zero  in  1  ALU result==0, combinational from the current selects
pc  out  PC_W  current program counter
halted  out  1  high in HALT state

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, pc=RESET_PC, IR=0, imm=0, Z=0. All outputs 0 except imem_addr=pc.
- Instruction format: [7:4] opcode, [3:2] rA, [1:0] rB.
- Opcodes:
  - 0 NOP.
  - 1..5 ALU ops: rA <= rA op rB; alu_op = opcode-1.
  - 6 MOV: rA <= rB.
  - 7 LDI: rA <= next byte.
  - 8 JMP: pc <= next byte.
  - 9 JZ: pc <= next byte if Z=1.
  - F HALT.
  - A..E: treated as NOP.
- States: IDLE, FETCH, DECODE, FETCH_IMM, EXEC, HALT.
- IDLE: when run=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On ack: IR <= imem_rdata, pc <= pc+1, go to DECODE.
  - An ack arriving while imem_req=0 is ignored.
- DECODE:
  - Opcodes 7/8/9 go to FETCH_IMM.
  - F goes to HALT.
  - All others go to EXEC.
- FETCH_IMM: same handshake as FETCH. On ack: imm <= imem_rdata, pc <= pc+1, go to EXEC.
- EXEC (exactly one cycle):
  - rf_selA=rA, rf_selB=rB throughout DECODE/FETCH_IMM/EXEC.
  - ALU ops: rf_we=1, wsel=0, Z <= alu_zero.
  - MOV: rf_we=1, wsel=2, Z unchanged.
  - LDI: rf_we=1, wsel=1.
  - JMP: pc <= imm.
  - JZ: pc <= imm if Z, else unchanged.
  - NOP: no effect.
  - Next state: FETCH if run=1, else IDLE.
- rf_we is high only in EXEC. JMP/JZ target overrides the increment already applied.
- Instruction latency: ALU/MOV/NOP = 3 cycles + fetch wait; LDI/JMP/JZ = 4 cycles + two fetch waits.
- HALT: halted=1, no fetch. Leave to IDLE only when run=0.
- run dropping mid-instruction: the current instruction completes, then the block idles.
- PC at 2^PC_W-1 increments to 0.
- Reset mid-handshake: imem_req falls asynchronously; a late ack is ignored.

Optional Feature:
CPU_CTRL_STEP_EN
- Defined:
  - Adds input port step (1 bit) and state STEP_WAIT.
  - EXEC goes to STEP_WAIT instead of FETCH.
  - STEP_WAIT advances to FETCH on a cycle with step=1 (rising-edge detected internally; a held level issues one instruction only). Goes to IDLE if run=0.
- Undefined: no step port; behaviour exactly as above.

Decomposition:
- Package cpu_pkg:
  - opcode enum (4-bit).
  - alu_op enum (3-bit).
  - wsel enum (2-bit).
  - state enum.
  - field-position localparams for opcode/rA/rB.
- Sub-module: cpu_ctrl_decode, combinational IR -> {needs_imm, is_alu, is_halt, alu_op, wsel, we} decode.
- FSM, PC, IR, imm and Z live in cpu_ctrl.

Test Plan:
- ALU: program LDI R1,#5; LDI R2,#5; SUB R1,R2 with 1-cycle-ack memory, run=1 -> R1=0, Z=1; rf_we high exactly 3 cycles total; pc=5.
- JZ: after above, JZ #0x10 -> pc=0x10. With Z=0, JZ #0x10 at pc=6 -> pc=8.
- Handshake: ack delayed 3 cycles -> imem_req high 4 cycles with imem_addr constant; stray ack while req=0 ignored, IR unchanged.
- HALT: 0xF0 fetched -> halted=1, no further imem_req while run=1; run=0 -> IDLE, halted=0.
- Reset: rst_n low during FETCH_IMM -> imem_req=0 same cycle; pc=0, state IDLE; no rf_we after release until run.
- Wrap/undefined: pc=0xFF fetching 0xA3 -> executes as NOP, pc=0x00, no rf_we.
